alarm_ctrl: RTL and testbench

Alarm controller that consumes the seconds/minutes/hours counts produced by the time-of-day counter and raises a ring output when the programmed alarm time is reached. Provides alarm-time programming, arm/disarm, snooze with a bounded retry count, stop, and an automatic ring timeout. Sits directly downstream of the time-of-day counter and drives the buzzer/LED stage.

---
 rtl/alarm_ctrl.sv | 161 ++++++++++++++++
 tb/tb_alarm_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_ctrl
//   Alarm controller fed by the time-of-day counter. Compares the running
//   time against a programmed alarm hour:minute. When the time matches, it
//   raises ring for RING_SECS second-ticks. The user can snooze the alarm
//   (bounded by MAX_SNOOZE per event) or stop it.
//
// Parameters
//   RING_SECS   : second-ticks of ringing before auto-timeout (1..63)
//   SNOOZE_SECS : snooze interval in second-ticks (1..511)
//   MAX_SNOOZE  : snoozes allowed per alarm event (0..7)
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   sec, min, hr      : current time from the time-of-day counter
//   set_en            : strobe, load set_hr/set_min as the alarm time
//   set_hr, set_min   : alarm time to load
//   alarm_on          : level, 1 = armed
//   snooze, stop      : debounced button strobes
//   ring              : buzzer drive (registered)
//   snoozing          : high while snoozing (registered)
//   snooze_cnt        : snoozes used in the current event
//   alm_hr, alm_min   : programmed alarm time
//   set_err           : one-cycle pulse after an out-of-range set_en
// -----------------------------------------------------------------------------
module alarm_ctrl #(
   parameter int RING_SECS   = 30,
   parameter int SNOOZE_SECS = 300,
   parameter int MAX_SNOOZE  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] sec,
   input  logic [5:0] min,
   input  logic [5:0] hr,
   input  logic       set_en,
   input  logic [5:0] set_hr,
   input  logic [5:0] set_min,
   input  logic       alarm_on,
   input  logic       snooze,
   input  logic       stop,
   output logic       ring,
   output logic       snoozing,
   output logic [2:0] snooze_cnt,
   output logic [5:0] alm_hr,
   output logic [5:0] alm_min,
   output logic       set_err
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RING   = 2'd1;
   localparam logic [1:0] S_SNOOZE = 2'd2;

   localparam logic [5:0] RING_LIM = 6'(RING_SECS);
   localparam logic [8:0] SNZ_LOAD = 9'(SNOOZE_SECS);
   localparam logic [2:0] SNZ_MAX  = 3'(MAX_SNOOZE);

   logic [1:0] state, state_n;
   logic [5:0] sec_q;
   logic [5:0] ring_cnt, ring_cnt_n;
   logic [8:0] snz_cnt, snz_cnt_n;
   logic [2:0] snooze_cnt_n;
   logic [5:0] alm_hr_n, alm_min_n;
   logic       tick, trig, set_ok;

   // A second-tick is any change of the seconds value. No particular number
   // of clock cycles per second is assumed.
   assign tick   = (sec != sec_q);
   assign set_ok = set_en && (set_hr < 6'd24) && (set_min < 6'd60);
   // The trigger needs the tick so that it fires only once, on entry to
   // second 0. It does not fire again while the time stays hh:mm:00.
   assign trig   = tick && (sec == 6'd0) && (hr == alm_hr) && (min == alm_min)
                   && alarm_on && (state == S_IDLE);

   always_comb begin
      state_n      = state;
      ring_cnt_n   = ring_cnt;
      snz_cnt_n    = snz_cnt;
      snooze_cnt_n = snooze_cnt;
      alm_hr_n     = alm_hr;
      alm_min_n    = alm_min;
      if (set_ok) begin
         // A valid set cancels any trigger that happens in the same cycle.
         alm_hr_n     = set_hr;
         alm_min_n    = set_min;
         state_n      = S_IDLE;
         snooze_cnt_n = 3'd0;
      end else if (!alarm_on) begin
         state_n      = S_IDLE;
         snooze_cnt_n = 3'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (trig) begin
                  state_n      = S_RING;
                  ring_cnt_n   = 6'd0;
                  snooze_cnt_n = 3'd0;
               end
            end
            S_RING: begin
               // A snooze with the budget used up behaves exactly like stop.
               if (stop || (snooze && (snooze_cnt == SNZ_MAX))) begin
                  state_n      = S_IDLE;
                  snooze_cnt_n = 3'd0;
               end else if (snooze) begin
                  state_n      = S_SNOOZE;
                  snooze_cnt_n = snooze_cnt + 3'd1;
                  snz_cnt_n    = SNZ_LOAD;
               end else if (tick) begin
                  ring_cnt_n = ring_cnt + 6'd1;
                  if (ring_cnt + 6'd1 == RING_LIM) begin
                     state_n      = S_IDLE;
                     snooze_cnt_n = 3'd0;
                  end
               end
            end
            S_SNOOZE: begin
               if (stop) begin
                  state_n      = S_IDLE;
                  snooze_cnt_n = 3'd0;
               end else if (tick && (snz_cnt != 9'd0)) begin
                  snz_cnt_n = snz_cnt - 9'd1;
                  if (snz_cnt == 9'd1) begin
                     state_n    = S_RING;
                     ring_cnt_n = 6'd0;
                  end
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // sec_q follows sec even during reset. This way, releasing reset
      // never produces a false tick.
      sec_q <= sec;
      if (rst) begin
         state      <= S_IDLE;
         ring_cnt   <= 6'd0;
         snz_cnt    <= 9'd0;
         snooze_cnt <= 3'd0;
         alm_hr     <= 6'd0;
         alm_min    <= 6'd0;
         ring       <= 1'b0;
         snoozing   <= 1'b0;
         set_err    <= 1'b0;
      end else begin
         state      <= state_n;
         ring_cnt   <= ring_cnt_n;
         snz_cnt    <= snz_cnt_n;
         snooze_cnt <= snooze_cnt_n;
         alm_hr     <= alm_hr_n;
         alm_min    <= alm_min_n;
         ring       <= (state_n == S_RING);
         snoozing   <= (state_n == S_SNOOZE);
         set_err    <= set_en && !set_ok;
      end
   end

endmodule

// File: tb/tb_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alarm_ctrl
//   Testbench for alarm_ctrl. A directed sequence runs first, followed by a
//   randomized phase. An event-level model of the alarm runs inside the
//   bench, and its expected outputs are compared with the DUT each cycle.
// -----------------------------------------------------------------------------
module tb_alarm_ctrl;

   localparam int RS = 30;
   localparam int SS = 300;
   localparam int MS = 3;

   logic       clk = 1'b0;
   logic       rst, set_en, alarm_on, snooze, stop;
   logic [5:0] sec, min, hr, set_hr, set_min;
   logic       ring, snoozing, set_err;
   logic [2:0] snooze_cnt;
   logic [5:0] alm_hr, alm_min;

   int tests = 0;
   int fails = 0;
   int t = 0;

   alarm_ctrl #(.RING_SECS(RS), .SNOOZE_SECS(SS), .MAX_SNOOZE(MS)) dut (
      .clk(clk), .rst(rst), .sec(sec), .min(min), .hr(hr),
      .set_en(set_en), .set_hr(set_hr), .set_min(set_min),
      .alarm_on(alarm_on), .snooze(snooze), .stop(stop),
      .ring(ring), .snoozing(snoozing), .snooze_cnt(snooze_cnt),
      .alm_hr(alm_hr), .alm_min(alm_min), .set_err(set_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model --------------------------------------
   // The model tracks the alarm as an event: whether it is ringing or
   // snoozed, how many seconds it has rung, how many snooze seconds are
   // left, and how many snoozes have been used.
   bit m_on = 0;
   bit m_ring, m_snz, m_err, m_tick;
   int m_prev, m_ticks, m_left, m_used, m_ahr, m_amin;

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            m_on = 1; m_ring = 0; m_snz = 0; m_err = 0;
            m_ticks = 0; m_left = 0; m_used = 0; m_ahr = 0; m_amin = 0;
            m_prev = int'(sec);
         end else begin
            m_tick = (int'(sec) != m_prev);
            m_prev = int'(sec);
            m_err  = set_en && !(set_hr < 24 && set_min < 60);
            if (set_en && !m_err) begin
               m_ahr = int'(set_hr); m_amin = int'(set_min);
               m_ring = 0; m_snz = 0; m_used = 0;
            end else if (!alarm_on) begin
               m_ring = 0; m_snz = 0; m_used = 0;
            end else if (m_ring) begin
               if (stop || (snooze && m_used == MS)) begin
                  m_ring = 0; m_used = 0;
               end else if (snooze) begin
                  m_ring = 0; m_snz = 1; m_used++; m_left = SS;
               end else if (m_tick) begin
                  m_ticks++;
                  if (m_ticks == RS) begin m_ring = 0; m_used = 0; end
               end
            end else if (m_snz) begin
               if (stop) begin
                  m_snz = 0; m_used = 0;
               end else if (m_tick) begin
                  m_left--;
                  if (m_left == 0) begin m_snz = 0; m_ring = 1; m_ticks = 0; end
               end
            end else if (m_tick && sec == 0 && int'(hr) == m_ahr && int'(min) == m_amin) begin
               m_ring = 1; m_ticks = 0; m_used = 0;
            end
         end
         #1;
         if (m_on) begin
            chk("mdl_ring", ring, m_ring);
            chk("mdl_snoozing", snoozing, m_snz);
            chk("mdl_snooze_cnt", snooze_cnt, m_used);
            chk("mdl_alm_hr", alm_hr, m_ahr);
            chk("mdl_alm_min", alm_min, m_amin);
            chk("mdl_set_err", set_err, m_err);
         end
      end
   end

   // ---------------- stimulus helpers ---------------------------------------
   task automatic drive_time();
      hr  = 6'(t / 3600);
      min = 6'((t / 60) % 60);
      sec = 6'(t % 60);
   endtask

   task automatic goto(input int h, input int m, input int s);
      @(negedge clk);
      t = h * 3600 + m * 60 + s;
      drive_time();
      @(negedge clk);
   endtask

   // Advance one second and hold it for 1..3 cycles.
   task automatic sec_step();
      @(negedge clk);
      t = (t + 1) % 86400;
      drive_time();
      repeat (1 + $urandom_range(0, 2)) @(negedge clk);
   endtask

   task automatic strobe(input bit s_snz, input bit s_stop);
      @(negedge clk);
      snooze = s_snz; stop = s_stop;
      @(negedge clk);
      snooze = 0; stop = 0;
   endtask

   task automatic do_set(input int h, input int m);
      @(negedge clk);
      set_en = 1; set_hr = 6'(h); set_min = 6'(m);
      @(negedge clk);
      set_en = 0;
   endtask

   task automatic trigger_0730();
      goto(7, 29, 59);
      sec_step();
      chk("trigger_ring", ring, 1);
   endtask

   // ---------------- main sequence ------------------------------------------
   initial begin
      rst = 1; set_en = 0; set_hr = 0; set_min = 0; alarm_on = 0;
      snooze = 0; stop = 0; t = 7 * 3600 + 29 * 60 + 58; drive_time();
      repeat (3) @(negedge clk);
      rst = 0;
      @(negedge clk);
      chk("rst_ring", ring, 0);
      chk("rst_alm_hr", alm_hr, 0);
      chk("rst_snooze_cnt", snooze_cnt, 0);

      // Set 07:30. While disarmed, no ring.
      do_set(7, 30);
      chk("set_alm_hr", alm_hr, 7);
      chk("set_alm_min", alm_min, 30);
      goto(7, 29, 59);
      sec_step();
      chk("disarmed_no_ring", ring, 0);

      // Armed: no ring at 07:29:59, ring after 07:30:00
      alarm_on = 1;
      goto(7, 29, 58);
      sec_step();
      chk("no_ring_2959", ring, 0);
      sec_step();
      chk("ring_0730", ring, 1);

      // Timeout after exactly RS ticks, and no re-trigger within 07:30
      repeat (RS - 1) sec_step();
      chk("ring_before_timeout", ring, 1);
      sec_step();
      chk("ring_timeout", ring, 0);
      chk("timeout_snooze_cnt", snooze_cnt, 0);
      repeat (25) sec_step();
      chk("no_retrigger", ring, 0);

      // Snooze at tick 5, repeated up to MS, then one more acts as stop
      trigger_0730();
      repeat (5) sec_step();
      for (int i = 1; i <= MS; i++) begin
         strobe(1, 0);
         chk("snz_ring_low", ring, 0);
         chk("snz_snoozing", snoozing, 1);
         chk("snz_cnt", snooze_cnt, i);
         repeat (SS - 1) sec_step();
         chk("snz_still_quiet", ring, 0);
         sec_step();
         chk("snz_reassert", ring, 1);
      end
      strobe(1, 0);
      chk("snz_over_ring", ring, 0);
      chk("snz_over_snoozing", snoozing, 0);
      chk("snz_over_cnt", snooze_cnt, 0);

      // Stop during RING, stop during SNOOZE, stop+snooze together
      trigger_0730();
      strobe(0, 1);
      chk("stop_ring", ring, 0);
      trigger_0730();
      strobe(1, 0);
      chk("pre_stop_snoozing", snoozing, 1);
      strobe(0, 1);
      chk("stop_snooze", snoozing, 0);
      chk("stop_snooze_cnt", snooze_cnt, 0);
      trigger_0730();
      strobe(1, 1);
      chk("stop_wins_ring", ring, 0);
      chk("stop_wins_snoozing", snoozing, 0);
      chk("stop_wins_cnt", snooze_cnt, 0);

      // Out-of-range set, then the 23:59 boundary
      do_set(24, 10);
      chk("set_err_pulse", set_err, 1);
      chk("bad_set_hr", alm_hr, 7);
      chk("bad_set_min", alm_min, 30);
      @(negedge clk);
      chk("set_err_clear", set_err, 0);
      do_set(23, 59);
      chk("set_2359_hr", alm_hr, 23);
      chk("set_2359_min", alm_min, 59);
      goto(23, 58, 59);
      sec_step();
      chk("ring_2359", ring, 1);

      // Reset during RING with sec held at 0
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("midrst_ring", ring, 0);
      chk("midrst_alm_hr", alm_hr, 0);
      chk("midrst_alm_min", alm_min, 0);
      repeat (5) @(negedge clk);
      chk("midrst_no_ring", ring, 0);

      // Randomized phase: alarms are often set one minute ahead so that
      // they trigger.
      do_set((t + 60) / 3600 % 24, ((t + 60) / 60) % 60);
      for (int c = 0; c < 8000; c++) begin
         @(negedge clk);
         snooze = ($urandom_range(0, 39) == 0);
         stop   = ($urandom_range(0, 79) == 0);
         set_en = 0;
         rst    = 0;
         if ($urandom_range(0, 1) == 0) begin
            t = (t + 1) % 86400;
            drive_time();
         end
         if ($urandom_range(0, 299) == 0) begin
            set_en = 1;
            if ($urandom_range(0, 2) != 0) begin
               set_hr  = 6'(((t + 60) % 86400) / 3600);
               set_min = 6'(((t + 60) / 60) % 60);
            end else begin
               set_hr  = 6'($urandom_range(0, 31));
               set_min = 6'($urandom_range(0, 63));
            end
         end
         if ($urandom_range(0, 499) == 0) alarm_on = ~alarm_on;
         if ($urandom_range(0, 2999) == 0) rst = 1;
      end
      @(negedge clk);
      snooze = 0; stop = 0; set_en = 0; rst = 0;
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
